// File: rtl/replica_pkg.sv
// Shared types for the replica-exchange optimiser host side: command and
// distance types, plus the scheduler state encoding and watchdog limit.
package replica_pkg;

  localparam int unsigned total_w = 32;

  typedef logic [total_w-1:0] total_data_t;

  typedef enum logic [1:0] {
    CmdIdle     = 2'd0,
    CmdExchEven = 2'd1,
    CmdExchOdd  = 2'd2,
    CmdAnneal   = 2'd3
  } opt_command_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StScan,
    StFinish
  } sched_state_t;

  // WAIT cycles tolerated without opt_done before the watchdog fires.
  localparam logic [15:0] sched_wdog_limit = 16'hFFFF;

endpackage

// File: rtl/best_tracker.sv
// Running minimum over scan samples. Strict-less update so that ties keep
// the earliest sample; clear restores the "nothing seen" state.
module best_tracker
  import replica_pkg::*;
#(
  parameter int unsigned idx_w  = 5,
  parameter int unsigned iter_w = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_valid,
  input  total_data_t       sample_dis,
  input  logic [idx_w-1:0]  sample_idx,
  input  logic [iter_w-1:0] sample_iter,
  output total_data_t       best_dis,
  output logic [idx_w-1:0]  best_idx,
  output logic [iter_w-1:0] best_iter
);

  // Capture a sample only when it strictly beats the held minimum.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      best_dis  <= '1;
      best_idx  <= '0;
      best_iter <= '0;
    end else if (sample_valid && (sample_dis < best_dis)) begin
      best_dis  <= sample_dis;
      best_idx  <= sample_idx;
      best_iter <= sample_iter;
    end
  end

endmodule

// File: rtl/opt_scheduler.sv
// Host-side sequencer: launches iter_count optimisation iterations with
// alternating commands and periodically walks the total-distance chain once
// around the ring to track the best distance seen.
// Optional feature: define OPT_SCHED_WATCHDOG_EN to enable a WAIT-state
// watchdog that raises a sticky error and finishes without a scan.
module opt_scheduler
  import replica_pkg::*;
#(
  parameter int unsigned replica_num = 32,
  parameter int unsigned iter_w      = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [iter_w-1:0]              iter_count,
  input  logic [15:0]                    check_interval,
  input  opt_command_t                   cmd0,
  input  opt_command_t                   cmd1,
  output logic                           opt_run,
  output opt_command_t                   opt_com,
  input  logic                           opt_done,
  output logic                           distance_shift,
  output total_data_t                    distance_wdata,
  input  total_data_t                    distance_rdata,
  output logic                           busy,
  output logic                           done,
  output total_data_t                    best_dis,
  output logic [$clog2(replica_num)-1:0] best_idx,
  output logic [iter_w-1:0]              best_iter,
  output logic                           error
);

  localparam int unsigned idx_w = $clog2(replica_num);
  localparam logic [idx_w-1:0] last_k = idx_w'(replica_num - 1);

  sched_state_t      state_q;
  logic [iter_w-1:0] iter_count_q, iter_cnt_q;
  logic [15:0]       check_interval_q, int_cnt_q;
  opt_command_t      cmd0_q, cmd1_q, opt_com_q;
  logic              abort_q;
  logic [idx_w-1:0]  scan_k_q;
  logic              opt_run_q, shift_q, busy_q, done_q;

`ifdef OPT_SCHED_WATCHDOG_EN
  logic [15:0] wdog_q;
  logic        error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  logic [iter_w-1:0] iter_next;
  logic [15:0]       int_next;
  logic              abort_now, scan_due, exhausted, start_accept;

  // Decisions taken when an iteration completes or a scan ends.
  always_comb begin
    iter_next    = iter_cnt_q + iter_w'(1);
    int_next     = int_cnt_q + 16'd1;
    abort_now    = abort_q | abort;
    scan_due     = ((check_interval_q != 16'd0) && (int_next == check_interval_q)) ||
                   (iter_next == iter_count_q) || abort_now;
    exhausted    = (iter_cnt_q == iter_count_q);
    start_accept = (state_q == StIdle) && start;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      iter_count_q     <= '0;
      check_interval_q <= '0;
      cmd0_q           <= CmdIdle;
      cmd1_q           <= CmdIdle;
      iter_cnt_q       <= '0;
      int_cnt_q        <= '0;
      abort_q          <= 1'b0;
      scan_k_q         <= '0;
      opt_run_q        <= 1'b0;
      opt_com_q        <= CmdIdle;
      shift_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
`ifdef OPT_SCHED_WATCHDOG_EN
      wdog_q           <= '0;
      error_q          <= 1'b0;
`endif
    end else begin
      opt_run_q <= 1'b0;
      done_q    <= 1'b0;
      if ((state_q != StIdle) && abort) abort_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            iter_count_q     <= iter_count;
            check_interval_q <= check_interval;
            cmd0_q           <= cmd0;
            cmd1_q           <= cmd1;
            iter_cnt_q       <= '0;
            int_cnt_q        <= '0;
            abort_q          <= 1'b0;
            scan_k_q         <= '0;
            busy_q           <= 1'b1;
`ifdef OPT_SCHED_WATCHDOG_EN
            error_q          <= 1'b0;
`endif
            if (iter_count == '0) begin
              state_q <= StScan;
              shift_q <= 1'b1;
            end else begin
              state_q   <= StLaunch;
              opt_run_q <= 1'b1;
              opt_com_q <= cmd0;
            end
          end
        end
        StLaunch: begin
          state_q <= StWait;
`ifdef OPT_SCHED_WATCHDOG_EN
          wdog_q  <= '0;
`endif
        end
        StWait: begin
          if (opt_done) begin
            iter_cnt_q <= iter_next;
            if (scan_due) begin
              state_q   <= StScan;
              shift_q   <= 1'b1;
              scan_k_q  <= '0;
              int_cnt_q <= '0;
            end else begin
              int_cnt_q <= int_next;
              state_q   <= StLaunch;
              opt_run_q <= 1'b1;
              opt_com_q <= iter_next[0] ? cmd1_q : cmd0_q;
            end
          end
`ifdef OPT_SCHED_WATCHDOG_EN
          else if (wdog_q == sched_wdog_limit) begin
            // Node controller is stuck: give up without touching the chain.
            state_q <= StFinish;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
`endif
        end
        StScan: begin
          if (scan_k_q == last_k) begin
            shift_q <= 1'b0;
            if (exhausted || abort_now) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= StLaunch;
              opt_run_q <= 1'b1;
              opt_com_q <= iter_cnt_q[0] ? cmd1_q : cmd0_q;
            end
          end else begin
            scan_k_q <= scan_k_q + idx_w'(1);
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign opt_run        = opt_run_q;
  assign opt_com        = opt_com_q;
  assign distance_shift = shift_q;
  // Recirculate the tail so a full walk leaves the chain unchanged.
  assign distance_wdata = distance_rdata;
  assign busy           = busy_q;
  assign done           = done_q;

  // Scan sample k reads the replica at the tail, index replica_num-1-k.
  best_tracker #(
    .idx_w  (idx_w),
    .iter_w (iter_w)
  ) u_best_tracker (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_accept),
    .sample_valid (shift_q),
    .sample_dis   (distance_rdata),
    .sample_idx   (last_k - scan_k_q),
    .sample_iter  (iter_cnt_q),
    .best_dis     (best_dis),
    .best_idx     (best_idx),
    .best_iter    (best_iter)
  );

endmodule

// File: doc/opt_scheduler.md
# opt_scheduler

Host-side sequencer for the replica-exchange optimiser. Issues a programmed number of optimisation iterations to the node controller, alternating between two opt commands. At a programmed interval it walks the total-distance shift chain once around the ring. While walking, it tracks the best (minimum) total distance, the replica that holds it and the iteration it was found at. It sits between the host register block and the optimiser top, driving `opt_run`/`opt_com`/`distance_shift`/`distance_wdata` and consuming `distance_rdata`.

## Interface
Parameters:
- replica_num, 32, replicas in the distance chain.
- iter_w, 24, width of the iteration counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle start pulse; ignored unless idle.
- abort  in  1  request early finish; sampled every cycle.
- iter_count  in  iter_w  iterations to run; latched at start.
- check_interval  in  16  scan after every N iterations; 0 = final scan only; latched at start.
- cmd0, cmd1  in  opt_command_t  command for even / odd iterations; latched at start.
- opt_run  out  1  one-cycle iteration launch pulse.
- opt_com  out  opt_command_t  command, valid while opt_run is high.
- opt_done  in  1  one-cycle pulse from the node controller when an iteration completes.
- distance_shift  out  1  shift the total-distance chain one position.
- distance_wdata  out  total_data_t  chain input; always equals distance_rdata (recirculation).
- distance_rdata  in  total_data_t  chain tail (replica replica_num-1 before a shift).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- best_dis  out  total_data_t  minimum distance seen.
- best_idx  out  $clog2(replica_num)  replica holding best_dis at its scan.
- best_iter  out  iter_w  iterations completed when best_dis was captured.
- error  out  1  watchdog timeout, sticky until next start.

## Operation
- States: IDLE, LAUNCH, WAIT, SCAN, FINISH.
- IDLE:
  - start latches the configuration.
  - Clears iter_cnt, int_cnt, abort flag and error.
  - Sets best_dis to all-ones, best_idx to 0, best_iter to 0.
  - Next state is SCAN if iter_count==0, otherwise LAUNCH.
- LAUNCH:
  - Drives opt_run=1 for one cycle.
  - opt_com = cmd0 if iter_cnt[0]==0, else cmd1.
  - Next state is WAIT.
- WAIT:
  - On opt_done: iter_cnt+1 and int_cnt+1.
  - Go to SCAN if any of these holds: int_cnt+1==check_interval (and check_interval≠0), iter_cnt+1==iter_count, or the abort flag is set.
  - Otherwise go to LAUNCH.
  - int_cnt clears on entry to SCAN.
- SCAN:
  - distance_shift=1 for exactly replica_num consecutive cycles, with scan counter k = 0..replica_num-1.
  - Sample k reads replica index replica_num-1-k.
  - best updates on strictly less only, so ties keep the earlier sample.
  - After the last shift the chain holds its original contents because wdata recirculates.
  - Next state is FINISH if iterations are exhausted or the abort flag is set, otherwise LAUNCH.
- FINISH: done=1 for one cycle, busy drops in the same cycle, next state IDLE.
- abort:
  - Sets the sticky flag in any non-IDLE state.
  - Never cuts an iteration or a scan short.
  - From LAUNCH/WAIT the block waits for opt_done, performs the final SCAN, then FINISH.
  - From SCAN it completes the scan, then FINISH.
  - Ignored in IDLE.
- start while busy: ignored.

## Timing
- Reset values: opt_run, distance_shift, busy, done and error are 0. opt_com = cmd encoding 0. best_dis is all-ones. best_idx and best_iter are 0. State is IDLE.
- Start accepted at cycle t:
  - busy=1 from t+1.
  - opt_run=1 at t+1.
  - If iter_count==0, distance_shift is high for t+1..t+replica_num and done=1 at t+replica_num+1.
- opt_done at cycle u, no scan due: next opt_run at u+1.
- opt_done at cycle u, scan due: shifts run u+1..u+replica_num, then LAUNCH or FINISH at u+replica_num+1.
- best_* register update the cycle after the winning sample and are stable from done onward.
- opt_done outside WAIT is ignored.
- Reset mid-operation returns to IDLE within one cycle. The chain may be left rotated; the host reloads it.

## Configuration
- OPT_SCHED_WATCHDOG_EN defined:
  - A 16-bit counter runs in WAIT and clears on entry.
  - If 65535 cycles pass with no opt_done, error=1 and the block goes directly to FINISH, with no scan.
- Undefined: no counter; error is tied 0; WAIT waits indefinitely.

## Structure
- replica_pkg gains:
  - sched_state_t enum (IDLE, LAUNCH, WAIT, SCAN, FINISH).
  - Constant sched_wdog_limit = 16'hFFFF.
- opt_command_t and total_data_t are reused from replica_pkg.
- One sub-module, best_tracker:
  - Takes a sample valid, value, index and iteration.
  - Provides a clear input.
  - Holds the strict-less minimum registers.

## Test plan
- replica_num=4, chain loaded 40,10,30,10; iter_count=0 → exactly 4 shift cycles; best_dis=10, best_idx=2; chain reads back 40,10,30,10; done 5 cycles after start.
- iter_count=5, check_interval=2, cmd0=A, cmd1=B, opt_done 3 cycles after each opt_run → opt_com sequence A,B,A,B,A; scans after iterations 2, 4 and 5; done once.
- Scan values improve from 50 (iteration 2) to 20 (iteration 4) and stay 20 at iteration 5 → best_dis=20, best_iter=4.
- abort during WAIT of iteration 2 of 10 → waits for opt_done, one scan, done; no further opt_run; iter_cnt=2.
- start pulsed while busy, and opt_done injected in SCAN → no effect on the sequence or counts.
- OPT_SCHED_WATCHDOG_EN defined, opt_done withheld → error=1 and done exactly 65536 cycles after entering WAIT; next start clears error.
